// File: rtl/design_32_arb.sv
// Round-robin arbiter/sequencer sharing one design_32 datapath among NREQ requesters.
// Optional WAIT timeout enabled by defining DESIGN_32_ARB_TIMEOUT_EN.
module design_32_arb #(
  parameter int W    = 12,
  parameter int NREQ = 4,
  parameter int IDW  = 2
`ifdef DESIGN_32_ARB_TIMEOUT_EN
  , parameter int TMO_CYC = 15
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic              dp_start,
  output logic [W-1:0]      dp_a,
  output logic [W-1:0]      dp_b,
  input  logic [W-1:0]      dp_y,
  input  logic              dp_valid,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_y,
  output logic              rsp_err
);

  // Response channel: a response transfers on any edge where rsp_valid && rsp_ready;
  // rsp_id/rsp_y/rsp_err stay stable while rsp_valid is high and not yet accepted.
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   ptr_d;
  logic [IDW-1:0]   win_d;
  logic             win_vld_d;
  logic [NREQ-1:0]  req_sh;
  int               idx;
  logic [NREQ-1:0]  gnt_q;
  logic             start_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [W-1:0]     rsp_y_q;

`ifdef DESIGN_32_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO_CYC + 1);
  logic [CW-1:0] cnt_q;
  logic          rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Scan downward so the lowest offset from ptr_q is the last (winning) assignment.
  always_comb begin
    win_d     = '0;
    win_vld_d = 1'b0;
    idx       = 0;
    req_sh    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx    = (int'(ptr_q) + k) % NREQ;
      req_sh = req >> idx;
      if (req_sh[0]) begin
        win_d     = IDW'(idx);
        win_vld_d = 1'b1;
      end
    end
    ptr_d = (int'(win_d) == NREQ - 1) ? '0 : win_d + IDW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      start_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
`ifdef DESIGN_32_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      gnt_q   <= '0;
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            gnt_q    <= {{(NREQ-1){1'b0}}, 1'b1} << win_d;
            start_q  <= 1'b1;
            a_q      <= a_in[win_d*W +: W];
            b_q      <= b_in[win_d*W +: W];
            rsp_id_q <= win_d;
            ptr_q    <= ptr_d;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
`ifdef DESIGN_32_ARB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        WAIT: begin
          if (dp_valid) begin
            rsp_y_q     <= dp_y;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
`ifdef DESIGN_32_ARB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
          end else if (cnt_q == CW'(TMO_CYC - 1)) begin
            rsp_y_q     <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign dp_start  = start_q;
  assign dp_a      = a_q;
  assign dp_b      = b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;

endmodule

// File: doc/design_32_arb.md
# design_32_arb

Round-robin arbiter and sequencer that shares one `design_32` datapath instance among `NREQ` requesters. It grants one requester at a time and captures that requester's operands. It then issues a single `start` to the datapath, waits for `valid`, and returns the result, tagged with the requester index, over a valid/ready response channel. The block sits between the requester ports and the `design_32` top-level `start`/`a`/`b`/`y`/`valid` pins.

## Interface
- `W`, 12, operand and result width; must match the datapath.
- `NREQ`, 4, number of requesters; legal range 2..8.
- `IDW`, 2, requester-index width; must satisfy 2^IDW ≥ NREQ.
- `TMO_CYC`, 15, timeout limit in cycles; used only when the timeout macro is defined.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester request level.
- `a_in`  in  NREQ*W  operand a; requester i uses bits [i*W +: W].
- `b_in`  in  NREQ*W  operand b, packed the same way as `a_in`.
- `gnt`  out  NREQ  one-hot grant, a single-cycle pulse.
- `dp_start`  out  1  start pulse to the datapath.
- `dp_a`, `dp_b`  out  W each  operands to the datapath.
- `dp_y`  in  W  datapath result.
- `dp_valid`  in  1  datapath result-valid.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response accepted.
- `rsp_id`  out  IDW  index of the requester being answered.
- `rsp_y`  out  W  result.
- `rsp_err`  out  1  response produced by timeout.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If `req` is non-zero, pick the winner round-robin: the first set bit at or above `ptr`, wrapping to index 0.
  - On that edge: register `gnt` = onehot(winner), capture the winner's `a_in`/`b_in` into the operand registers, set `rsp_id` = winner, set `ptr` = winner+1 (mod NREQ), then go to ISSUE.
  - If `req` is zero, stay in IDLE.
- ISSUE:
  - `dp_start` = 1 for exactly this one cycle; `gnt` is high during this same cycle.
  - Go to WAIT unconditionally.
- WAIT:
  - On an edge where `dp_valid` = 1: capture `dp_y` into `rsp_y`, clear `rsp_err`, go to RESP.
  - With the timeout feature, see Configuration.
- RESP:
  - `rsp_valid` = 1. `rsp_id`, `rsp_y` and `rsp_err` are held stable.
  - On an edge where `rsp_valid` and `rsp_ready` are both 1, go to IDLE.
- `dp_a`/`dp_b` are driven continuously from the operand registers. They change only at the grant edge and are stable from ISSUE through RESP.
- `dp_valid` is ignored in IDLE, ISSUE and RESP. A stale or extra pulse has no effect.
- `req` is sampled only in IDLE. A requester keeps `req` high until it sees `gnt`. A `req` dropped before the grant edge is never granted.
- If a requester still has `req` high after its grant, that is a new request and is served again in its round-robin turn.
- All arithmetic is W-bit; `rsp_y` is `dp_y` unmodified.

## Timing
- Reset values (asynchronous): state IDLE, `ptr` 0, and `gnt`, `dp_start`, `dp_a`, `dp_b`, `rsp_valid`, `rsp_id`, `rsp_y`, `rsp_err` all 0.
- Reset asserted in any state aborts the transaction immediately. No response is produced and no `dp_start` is issued after reset.
- Let edge k be the edge at which `req` is sampled in IDLE:
  - `gnt` and `dp_start` are high during cycle k+1.
  - The earliest accepted `dp_valid` is at edge k+2.
  - `rsp_valid` rises during the cycle after the edge at which `dp_valid` is sampled.
- Minimum request-to-`rsp_valid` latency is 3 cycles.
- A response accepted at edge m returns the FSM to IDLE during cycle m+1. The next grant edge is therefore m+1, and a back-to-back transaction costs 1 idle cycle.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- Macro: `DESIGN_32_ARB_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to WAIT and increments each cycle spent in WAIT.
  - If the counter reaches `TMO_CYC` without `dp_valid`, go to RESP with `rsp_y` = 0 and `rsp_err` = 1.
  - If `dp_valid` and the timeout occur on the same edge, `dp_valid` wins and `rsp_err` = 0.
- Not defined: there is no counter, `rsp_err` is tied to 0, and WAIT lasts indefinitely until `dp_valid`.

## Test plan
- Single request: reset, `req`=0001, `a_in[0]`=12'h123, `b_in[0]`=12'h011, `dp_valid` returned 2 cycles after `dp_start` with `dp_y`=12'h134 → `gnt`=0001 for one cycle, `dp_a`=12'h123, `rsp_valid` with `rsp_id`=0, `rsp_y`=12'h134.
- Round robin: `req`=1111 held high, `rsp_ready`=1 → grants go 0001, 0010, 0100, 1000, 0001, and `rsp_id` follows 0,1,2,3,0.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid`, `rsp_id` and `rsp_y` stay constant, no new `gnt` or `dp_start` is issued, and the next grant comes 1 cycle after acceptance.
- Spurious `dp_valid`: pulse `dp_valid` in IDLE and during ISSUE → no state change and no response; only the `dp_valid` sampled in WAIT is captured.
- Timeout (macro defined, `TMO_CYC`=15): never assert `dp_valid` → 15 cycles after entering WAIT, `rsp_valid`=1 with `rsp_err`=1 and `rsp_y`=0. Repeat with `dp_valid` on the limit edge → `rsp_err`=0.
- Reset mid-operation: assert `rst_n`=0 during WAIT → all outputs 0 immediately and `ptr`=0. After release with `req`=0110, the first grant is 0010.
